// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with registered output and optional
// store-and-forward gating on tlast boundaries.
module axis_pkt_fifo #(
   parameter int WIDTH        = 32,
   parameter int DEEP         = 32,
   parameter int DEEP_BITS    = $clog2(DEEP),
   parameter int PKT_MODE     = 0,
   parameter int AFULL_THRESH = DEEP - 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     s_rx_tdata,
   input  logic                 s_rx_tlast,
   input  logic                 s_rx_tvalid,
   output logic                 s_rx_tready,
   output logic [WIDTH-1:0]     m_tx_tdata,
   output logic                 m_tx_tlast,
   output logic                 m_tx_tvalid,
   input  logic                 m_tx_tready,
   output logic [DEEP_BITS:0]   fifo_used,
   output logic                 fifo_full,
   output logic                 fifo_empty,
   output logic                 fifo_afull,
   output logic [DEEP_BITS:0]   pkt_count
);

   localparam logic [DEEP_BITS:0]   CNT_FULL  = DEEP[DEEP_BITS:0];
   localparam logic [DEEP_BITS:0]   CNT_AFULL = AFULL_THRESH[DEEP_BITS:0];
   localparam logic [DEEP_BITS:0]   CNT_ONE   = 1;
   localparam logic [DEEP_BITS-1:0] PTR_ONE   = 1;

   logic [WIDTH:0]        mem [DEEP];
   logic [DEEP_BITS-1:0]  wr_ptr;
   logic [DEEP_BITS-1:0]  rd_ptr;
   logic [DEEP_BITS:0]    mem_count;
   logic                  cut;
   logic                  wr_en;
   logic                  rd_en;
   logic                  rd_allow;
   logic                  rd_last;
   logic                  wr_last;

   assign fifo_full   = (mem_count == CNT_FULL);
   assign s_rx_tready = ~fifo_full;
   assign wr_en       = s_rx_tvalid && !fifo_full;
   assign wr_last     = wr_en && s_rx_tlast;

   // Store-and-forward holds reads until a whole packet is in memory,
   // unless an oversize packet forced cut-through.
   assign rd_allow = (PKT_MODE == 0) || (pkt_count != '0) || cut;
   assign rd_en    = (mem_count != '0) && rd_allow
                     && (!m_tx_tvalid || m_tx_tready);
   assign rd_last  = mem[rd_ptr][WIDTH];

   assign fifo_used  = mem_count + {{DEEP_BITS{1'b0}}, m_tx_tvalid};
   assign fifo_empty = (fifo_used == '0);
   assign fifo_afull = (mem_count >= CNT_AFULL);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {s_rx_tlast, s_rx_tdata};
      end
      if (rd_en) begin
         {m_tx_tlast, m_tx_tdata} <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mem_count   <= '0;
         pkt_count   <= '0;
         cut         <= 1'b0;
         m_tx_tvalid <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({wr_en, rd_en})
            2'b10:   mem_count <= mem_count + CNT_ONE;
            2'b01:   mem_count <= mem_count - CNT_ONE;
            default: mem_count <= mem_count;
         endcase
         unique case ({wr_last, rd_en && rd_last})
            2'b10:   pkt_count <= pkt_count + CNT_ONE;
            2'b01:   pkt_count <= pkt_count - CNT_ONE;
            default: pkt_count <= pkt_count;
         endcase
         if (rd_en) begin
            m_tx_tvalid <= 1'b1;
         end else if (m_tx_tready) begin
            m_tx_tvalid <= 1'b0;
         end
         if (PKT_MODE != 0) begin
            if (rd_en && rd_last) begin
               cut <= 1'b0;
            end else if (fifo_full && pkt_count == '0) begin
               cut <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench: streaming instance (PKT_MODE=0, DEEP=32) and
// packet instance (PKT_MODE=1, DEEP=16).
module tb_axis_pkt_fifo;

   logic clk;
   int   checks;
   int   failures;

   logic        a_rst, a_vld, a_last, a_rdy;
   logic [31:0] a_data;
   logic        a_s_rdy, a_mv, a_mlast;
   logic [31:0] a_mdata;
   logic [5:0]  a_used, a_pkt;
   logic        a_full, a_empty, a_afull;

   logic        b_rst, b_vld, b_last, b_rdy;
   logic [15:0] b_data;
   logic        b_s_rdy, b_mv, b_mlast;
   logic [15:0] b_mdata;
   logic [4:0]  b_used, b_pkt;
   logic        b_full, b_empty, b_afull;

   logic [32:0] aq [$];
   logic [16:0] bq [$];

   axis_pkt_fifo #(.WIDTH(32), .DEEP(32), .PKT_MODE(0)) u_a (
      .clk(clk), .rst(a_rst),
      .s_rx_tdata(a_data), .s_rx_tlast(a_last),
      .s_rx_tvalid(a_vld), .s_rx_tready(a_s_rdy),
      .m_tx_tdata(a_mdata), .m_tx_tlast(a_mlast),
      .m_tx_tvalid(a_mv), .m_tx_tready(a_rdy),
      .fifo_used(a_used), .fifo_full(a_full),
      .fifo_empty(a_empty), .fifo_afull(a_afull),
      .pkt_count(a_pkt)
   );

   axis_pkt_fifo #(.WIDTH(16), .DEEP(16), .PKT_MODE(1)) u_b (
      .clk(clk), .rst(b_rst),
      .s_rx_tdata(b_data), .s_rx_tlast(b_last),
      .s_rx_tvalid(b_vld), .s_rx_tready(b_s_rdy),
      .m_tx_tdata(b_mdata), .m_tx_tlast(b_mlast),
      .m_tx_tvalid(b_mv), .m_tx_tready(b_rdy),
      .fifo_used(b_used), .fifo_full(b_full),
      .fifo_empty(b_empty), .fifo_afull(b_afull),
      .pkt_count(b_pkt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [31:0] data;
      logic        last;
      logic        rdy;
      logic        e_mv;
      logic [31:0] e_data;
      logic        e_last;
      int          e_used;
      int          e_pkt;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_reset();
      a_rst = 1'b1; a_vld = 1'b0; a_rdy = 1'b0;
      step();
      a_rst = 1'b0;
      aq.delete();
   endtask

   task automatic b_reset();
      b_rst = 1'b1; b_vld = 1'b0; b_rdy = 1'b0;
      step();
      b_rst = 1'b0;
      bq.delete();
   endtask

   task automatic b_send(input logic [15:0] d, input logic l);
      b_vld = 1'b1; b_data = d; b_last = l;
      if (b_s_rdy) bq.push_back({l, d});
      step();
      b_vld = 1'b0;
   endtask

   // Drain n words with ready held high, checking order against bq.
   task automatic b_collect(input int n, input string nm);
      int got = 0;
      int cyc = 0;
      logic [16:0] e;
      b_vld = 1'b0;
      b_rdy = 1'b1;
      while (got < n && cyc < 200) begin
         if (b_mv) begin
            e = (bq.size() > 0) ? bq.pop_front() : 17'h1ffff;
            chk($sformatf("%s_w%0d", nm, got),
                64'({b_mlast, b_mdata}), 64'(e));
            got++;
         end
         step();
         cyc++;
      end
      chk({nm, "_count"}, 64'(got), 64'(n));
   endtask

   initial begin
      int sent, rcvd, cyc, acc, first_af, got;
      logic seen_full, early;
      logic [32:0] e;

      clk = 1'b0; checks = 0; failures = 0;
      a_rst = 1'b1; a_vld = 1'b0; a_last = 1'b0; a_rdy = 1'b0;
      a_data = '0;
      b_rst = 1'b1; b_vld = 1'b0; b_last = 1'b0; b_rdy = 1'b0;
      b_data = '0;

      tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1,
                  1'b0, 32'h00, 1'b0, 0, 0};
      tbl[1]  = '{1'b0, 1'b1, 32'hA1, 1'b0, 1'b1,
                  1'b0, 32'h00, 1'b0, 1, 0};
      tbl[2]  = '{1'b0, 1'b1, 32'hA2, 1'b1, 1'b1,
                  1'b1, 32'hA1, 1'b0, 2, 1};
      tbl[3]  = '{1'b0, 1'b0, 32'hFF, 1'b1, 1'b1,
                  1'b1, 32'hA2, 1'b1, 1, 0};
      tbl[4]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0,
                  1'b1, 32'hA2, 1'b1, 1, 0};
      tbl[5]  = '{1'b0, 1'b1, 32'hB1, 1'b1, 1'b0,
                  1'b1, 32'hA2, 1'b1, 2, 1};
      tbl[6]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1,
                  1'b1, 32'hB1, 1'b1, 1, 0};
      tbl[7]  = '{1'b0, 1'b1, 32'hC1, 1'b0, 1'b1,
                  1'b0, 32'h00, 1'b0, 1, 0};
      tbl[8]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1,
                  1'b1, 32'hC1, 1'b0, 1, 0};
      tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1,
                  1'b0, 32'h00, 1'b0, 0, 0};
      tbl[10] = '{1'b1, 1'b1, 32'hD1, 1'b1, 1'b1,
                  1'b0, 32'h00, 1'b0, 0, 0};

      for (int i = 0; i < 11; i++) begin
         a_rst = tbl[i].rst; a_vld = tbl[i].vld;
         a_data = tbl[i].data; a_last = tbl[i].last;
         a_rdy = tbl[i].rdy;
         step();
         chk($sformatf("vec%0d_mv", i), 64'(a_mv), 64'(tbl[i].e_mv));
         chk($sformatf("vec%0d_used", i), 64'(a_used),
             64'(tbl[i].e_used));
         chk($sformatf("vec%0d_pkt", i), 64'(a_pkt),
             64'(tbl[i].e_pkt));
         chk($sformatf("vec%0d_empty", i), 64'(a_empty),
             64'(tbl[i].e_used == 0));
         chk($sformatf("vec%0d_srdy", i), 64'(a_s_rdy), 64'(1));
         if (tbl[i].e_mv)
            chk($sformatf("vec%0d_data", i), 64'({a_mlast, a_mdata}),
                64'({tbl[i].e_last, tbl[i].e_data}));
      end
      a_rst = 1'b0;
      chk("rst_full", 64'(a_full), 64'(0));
      chk("rst_afull", 64'(a_afull), 64'(0));

      // Two-edge latency, then random valid/ready streaming.
      a_reset();
      a_vld = 1'b1; a_data = 32'h1000; a_last = 1'b0; a_rdy = 1'b0;
      aq.push_back({1'b0, 32'h1000});
      step();
      chk("lat_edge1_mv", 64'(a_mv), 64'(0));
      a_vld = 1'b0;
      step();
      chk("lat_edge2_mv", 64'(a_mv), 64'(1));
      sent = 1; rcvd = 0; cyc = 0;
      while (rcvd < 100 && cyc < 2000) begin
         a_vld  = (sent < 100) && ($urandom_range(0, 3) != 0);
         a_data = 32'h1000 + sent;
         a_last = (sent % 7 == 6);
         a_rdy  = ($urandom_range(0, 3) != 0);
         if (a_vld && a_s_rdy) begin
            aq.push_back({a_last, a_data});
            sent++;
         end
         if (a_mv && a_rdy) begin
            e = (aq.size() > 0) ? aq.pop_front() : 33'h1ffffffff;
            chk($sformatf("stream_w%0d", rcvd),
                64'({a_mlast, a_mdata}), 64'(e));
            rcvd++;
         end
         step();
         cyc++;
      end
      chk("stream_count", 64'(rcvd), 64'(100));
      chk("stream_end_pkt", 64'(a_pkt), 64'(0));

      // Full-rate: 20 words in and out in 22 edges.
      a_reset();
      a_rdy = 1'b1; sent = 0; rcvd = 0; cyc = 0;
      while (rcvd < 20 && cyc < 100) begin
         a_vld = (sent < 20);
         a_data = 32'h2000 + sent;
         a_last = 1'b0;
         if (a_vld && a_s_rdy) sent++;
         if (a_mv) begin
            chk($sformatf("rate_w%0d", rcvd), 64'(a_mdata),
                64'(32'h2000 + rcvd));
            rcvd++;
         end
         step();
         cyc++;
      end
      chk("rate_edges", 64'(cyc), 64'(22));

      // Fill with output stalled.
      a_reset();
      acc = 0; first_af = 0;
      for (int i = 0; i < 40; i++) begin
         a_vld = 1'b1; a_data = 32'h3000 + i; a_last = (i == 39);
         if (a_s_rdy) acc++;
         step();
         if (a_afull && first_af == 0) first_af = acc;
      end
      a_vld = 1'b0;
      chk("fill_accepted", 64'(acc), 64'(33));
      chk("fill_full", 64'(a_full), 64'(1));
      chk("fill_used", 64'(a_used), 64'(33));
      chk("fill_srdy", 64'(a_s_rdy), 64'(0));
      chk("fill_afull_at", 64'(first_af), 64'(29));
      a_rdy = 1'b1; got = 0; cyc = 0;
      while (got < 33 && cyc < 100) begin
         if (a_mv) begin
            chk($sformatf("fill_w%0d", got), 64'(a_mdata),
                64'(32'h3000 + got));
            got++;
         end
         step();
         cyc++;
      end
      chk("fill_drain_count", 64'(got), 64'(33));
      chk("fill_drain_empty", 64'(a_empty), 64'(1));

      // Store-and-forward: nothing leaves before tlast.
      b_reset();
      b_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b_send(16'h5000 + 16'(i), (i == 4));
         chk($sformatf("pkt_hold_mv%0d", i), 64'(b_mv), 64'(0));
      end
      chk("pkt_count_one", 64'(b_pkt), 64'(1));
      b_collect(5, "pkt5");
      chk("pkt_count_zero", 64'(b_pkt), 64'(0));

      // tlast write and tlast read on the same edge.
      b_reset();
      b_send(16'h0A01, 1'b0);
      b_send(16'h0A02, 1'b1);
      step();
      chk("sim_pre_data", 64'({b_mv, b_mlast, b_mdata}),
          64'({1'b1, 1'b0, 16'h0A01}));
      chk("sim_pre_pkt", 64'(b_pkt), 64'(1));
      void'(bq.pop_front());
      b_rdy = 1'b1;
      b_send(16'h0B01, 1'b1);
      chk("sim_pkt_kept", 64'(b_pkt), 64'(1));
      chk("sim_data", 64'({b_mv, b_mlast, b_mdata}),
          64'({1'b1, 1'b1, 16'h0A02}));
      void'(bq.pop_front());
      step();
      chk("sim_next", 64'({b_mv, b_mlast, b_mdata}),
          64'({1'b1, 1'b1, 16'h0B01}));
      chk("sim_pkt_zero", 64'(b_pkt), 64'(0));

      // Oversize packet forces cut-through.
      b_reset();
      b_rdy = 1'b1; sent = 0; rcvd = 0; cyc = 0;
      seen_full = 1'b0; early = 1'b0;
      while (rcvd < 40 && cyc < 400) begin
         if (b_full) seen_full = 1'b1;
         if (b_mv && !seen_full) early = 1'b1;
         b_vld = (sent < 40);
         b_data = 16'h6000 + 16'(sent);
         b_last = (sent == 39);
         if (b_vld && b_s_rdy) sent++;
         if (b_mv) begin
            chk($sformatf("big_w%0d", rcvd), 64'({b_mlast, b_mdata}),
                64'({(rcvd == 39), 16'h6000 + 16'(rcvd)}));
            rcvd++;
         end
         step();
         cyc++;
      end
      b_vld = 1'b0;
      chk("big_count", 64'(rcvd), 64'(40));
      chk("big_seen_full", 64'(seen_full), 64'(1));
      chk("big_early_out", 64'(early), 64'(0));
      chk("big_pkt_zero", 64'(b_pkt), 64'(0));
      for (int i = 0; i < 3; i++) begin
         b_send(16'h6100 + 16'(i), (i == 2));
         chk($sformatf("big_after_hold%0d", i), 64'(b_mv), 64'(0));
      end
      b_collect(3, "big_after");

      // Reset mid-packet discards stored words.
      b_reset();
      b_rdy = 1'b1;
      for (int i = 0; i < 10; i++) b_send(16'h7000 + 16'(i), 1'b0);
      chk("mid_used10", 64'(b_used), 64'(10));
      chk("mid_mv_hold", 64'(b_mv), 64'(0));
      b_rst = 1'b1;
      step();
      b_rst = 1'b0;
      bq.delete();
      chk("mid_rst_used", 64'(b_used), 64'(0));
      chk("mid_rst_mv", 64'(b_mv), 64'(0));
      chk("mid_rst_pkt", 64'(b_pkt), 64'(0));
      chk("mid_rst_empty", 64'(b_empty), 64'(1));
      for (int i = 0; i < 4; i++) begin
         b_send(16'h7100 + 16'(i), (i == 3));
         chk($sformatf("mid_new_hold%0d", i), 64'(b_mv), 64'(0));
      end
      b_collect(4, "mid_new");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
